// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - handshake bundle between adder array, accumulator and write-back
interface psum_accumulator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM        = 4,
    parameter int K_WIDTH    = 16
);
    logic [K_WIDTH-1:0]                k_len_in;
    logic                              in_valid;
    logic                              in_ready;
    logic [NUM-1:0][DATA_WIDTH-1:0]    data_in;
    logic                              out_valid;
    logic                              out_ready;
    logic [NUM-1:0][DATA_WIDTH-1:0]    data_out;

    modport slave (
        input  k_len_in,
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out
    );

    modport master (
        output k_len_in,
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out
    );
endinterface

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - element-wise accumulation of partial-sum vectors over K-beat tiles
module psum_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM        = 4,
    parameter int K_WIDTH    = 16
) (
    input  logic               clk,
    input  logic               rst,
    psum_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [K_WIDTH-1:0] K_ONE = K_WIDTH'(1);

    state_t                          state_q;
    logic [NUM-1:0][DATA_WIDTH-1:0]  acc_q;
    logic [K_WIDTH-1:0]              cnt_q;
    logic [K_WIDTH-1:0]              klen_q;
    logic                            out_valid_q;

    logic                            accept;
    logic [K_WIDTH-1:0]              klen_d;
    logic [K_WIDTH-1:0]              cnt_d;

    // A new tile can start in the same cycle the held result drains.
    assign bus.in_ready  = !rst && ((state_q == HOLD) ? bus.out_ready : 1'b1);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = acc_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign klen_d = (bus.k_len_in == '0) ? K_ONE : bus.k_len_in;
    assign cnt_d  = cnt_q + K_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            klen_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q       <= bus.data_in;
                        klen_q      <= klen_d;
                        cnt_q       <= K_ONE;
                        state_q     <= (klen_d == K_ONE) ? HOLD : ACC;
                        out_valid_q <= (klen_d == K_ONE);
                    end
                end
                ACC: begin
                    if (accept) begin
                        for (int i = 0; i < NUM; i++) begin
                            acc_q[i] <= acc_q[i] + bus.data_in[i];
                        end
                        cnt_q <= cnt_d;
                        if (cnt_d == klen_q) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            acc_q       <= bus.data_in;
                            klen_q      <= klen_d;
                            cnt_q       <= K_ONE;
                            state_q     <= (klen_d == K_ONE) ? HOLD : ACC;
                            out_valid_q <= (klen_d == K_ONE);
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed self-checking bench for psum_accumulator
module tb_psum_accumulator;
    localparam int DW  = 32;
    localparam int NL  = 4;
    localparam int KW  = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   xfers;
    int   x0;

    psum_accumulator_if #(.DATA_WIDTH(DW), .NUM(NL), .K_WIDTH(KW)) bus ();

    psum_accumulator #(.DATA_WIDTH(DW), .NUM(NL), .K_WIDTH(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) xfers++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] splat(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        xfers = 0;
        rst = 1'b1;
        bus.k_len_in = '0;
        bus.in_valid = 1'b0;
        bus.data_in = '0;
        bus.out_ready = 1'b1;

        // Reset
        tick();
        chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
        tick();
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_data_out", bus.data_out, 128'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(bus.in_ready), 128'd1);

        // Basic tile: k_len=4, lane i = i+1
        x0 = xfers;
        bus.k_len_in = 16'd4;
        bus.in_valid = 1'b1;
        bus.data_in = {32'd4, 32'd3, 32'd2, 32'd1};
        tick(); tick(); tick();
        chk("basic_not_early", 128'(bus.out_valid), 128'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("basic_valid", 128'(bus.out_valid), 128'd1);
        chk("basic_sum", bus.data_out, {32'd16, 32'd12, 32'd8, 32'd4});
        tick();
        chk("basic_drained", 128'(bus.out_valid), 128'd0);
        chk("basic_xfers", 128'(xfers - x0), 128'd1);

        // Wrap-around and signed lanes
        bus.k_len_in = 16'd2;
        bus.in_valid = 1'b1;
        bus.data_in = {32'd0, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        tick();
        bus.data_in = {32'd0, 32'd0, 32'd3, 32'd2};
        tick();
        bus.in_valid = 1'b0;
        chk("wrap_valid", 128'(bus.out_valid), 128'd1);
        chk("wrap_sum", bus.data_out, {32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001});
        tick();

        // Back-pressure with bubbles
        x0 = xfers;
        bus.out_ready = 1'b0;
        bus.k_len_in = 16'd3;
        bus.data_in = {32'd40, 32'd30, 32'd20, 32'd10};
        bus.in_valid = 1'b1; tick();
        bus.in_valid = 1'b0; tick();
        chk("bp_mid_valid", 128'(bus.out_valid), 128'd0);
        bus.in_valid = 1'b1; tick();
        bus.in_valid = 1'b0; tick();
        bus.in_valid = 1'b1; tick();
        bus.k_len_in = 16'd1;
        bus.data_in = splat(32'd1);
        chk("bp_hold_in_ready", 128'(bus.in_ready), 128'd0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_stall_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_stall_data", bus.data_out, {32'd120, 32'd90, 32'd60, 32'd30});
            chk("bp_stall_in_ready", 128'(bus.in_ready), 128'd0);
            tick();
        end
        chk("bp_no_xfer", 128'(xfers - x0), 128'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_next_valid", 128'(bus.out_valid), 128'd1);
        chk("bp_next_data", bus.data_out, splat(32'd1));
        tick();
        chk("bp_next_drained", 128'(bus.out_valid), 128'd0);
        chk("bp_xfers", 128'(xfers - x0), 128'd2);

        // Back-to-back k_len=1 tiles
        x0 = xfers;
        bus.k_len_in = 16'd1;
        bus.in_valid = 1'b1;
        bus.data_in = splat(32'd10);
        #1;
        chk("b2b_in_ready0", 128'(bus.in_ready), 128'd1);
        tick();
        bus.data_in = splat(32'd20);
        chk("b2b_out10", bus.data_out, splat(32'd10));
        chk("b2b_in_ready1", 128'(bus.in_ready & bus.out_valid), 128'd1);
        tick();
        bus.data_in = splat(32'd30);
        chk("b2b_out20", bus.data_out, splat(32'd20));
        chk("b2b_in_ready2", 128'(bus.in_ready & bus.out_valid), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_out30", bus.data_out, splat(32'd30));
        chk("b2b_valid30", 128'(bus.out_valid), 128'd1);
        tick();
        chk("b2b_xfers", 128'(xfers - x0), 128'd3);

        // k_len=0 behaves as 1
        bus.k_len_in = 16'd0;
        bus.in_valid = 1'b1;
        bus.data_in = splat(32'd7);
        tick();
        bus.in_valid = 1'b0;
        chk("k0_valid", 128'(bus.out_valid), 128'd1);
        chk("k0_data", bus.data_out, splat(32'd7));
        tick();

        // k_len changed mid-tile is ignored
        bus.k_len_in = 16'd4;
        bus.in_valid = 1'b1;
        bus.data_in = splat(32'd1);
        tick();
        bus.k_len_in = 16'd2;
        tick();
        chk("kchg_beat2", 128'(bus.out_valid), 128'd0);
        tick();
        chk("kchg_beat3", 128'(bus.out_valid), 128'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("kchg_valid", 128'(bus.out_valid), 128'd1);
        chk("kchg_data", bus.data_out, splat(32'd4));
        tick();

        // Reset mid-tile
        x0 = xfers;
        bus.k_len_in = 16'd4;
        bus.in_valid = 1'b1;
        bus.data_in = splat(32'd5);
        tick(); tick();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("mrst_in_ready", 128'(bus.in_ready), 128'd0);
        tick();
        rst = 1'b0;
        chk("mrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("mrst_data", bus.data_out, 128'd0);
        bus.in_valid = 1'b1;
        bus.data_in = splat(32'd1);
        tick(); tick(); tick();
        chk("mrst_not_early", 128'(bus.out_valid), 128'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("mrst_valid", 128'(bus.out_valid), 128'd1);
        chk("mrst_data_clean", bus.data_out, splat(32'd4));
        tick();
        chk("mrst_xfers", 128'(xfers - x0), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream stage of the pairwise adder array in the GEMM datapath.
- Each cycle the adder array produces NUM reduced partial sums. This block adds those vectors element-wise over K_LEN consecutive accepted beats, which form one output tile.
- It then presents the finished NUM-wide result vector with a valid/ready handshake to the write-back stage.
- Inputs and outputs both use valid/ready handshakes, so the block buffers exactly one result tile.

Parameters:
- DATA_WIDTH, 32: width of each lane, for input partial sums and for accumulators.
- NUM, 4: number of lanes; must match the NUM of the upstream adder array.
- K_WIDTH, 16: width of the tile-length input and of the internal beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- k_len_in  input  K_WIDTH  beats per tile. Sampled only on the first beat of a tile. A value of 0 is treated as 1.
- in_valid  input  1  upstream has a partial-sum vector on data_in.
- in_ready  output  1  block accepts data_in this cycle.
- data_in  input  [NUM-1:0][DATA_WIDTH-1:0]  partial-sum vector from the adder array.
- out_valid  output  1  data_out holds a finished tile result.
- out_ready  input  1  downstream consumes data_out this cycle.
- data_out  output  [NUM-1:0][DATA_WIDTH-1:0]  accumulated tile result.

Behaviour:
- Handshakes:
  - An input beat transfers on the rising edge when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Reset:
  - state=IDLE; accumulators, count and k_len register cleared to 0.
  - out_valid=0, data_out=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- State IDLE:
  - out_valid=0, in_ready=1.
  - On an accepted beat: acc[i] <= data_in[i]; klen <= max(k_len_in,1); cnt <= 1.
  - Next state is HOLD if the effective klen == 1, else ACC.
- State ACC:
  - out_valid=0, in_ready=1.
  - On an accepted beat: acc[i] <= acc[i] + data_in[i]; cnt <= cnt+1.
  - When cnt+1 == klen, go to HOLD.
  - With no beat, hold all state; bubbles are allowed.
- State HOLD:
  - out_valid=1, data_out=acc.
  - in_ready = out_ready, i.e. a new tile may start in the same cycle the result drains.
  - On out_ready && !in_valid: go to IDLE.
  - On out_ready && in_valid: perform the IDLE first-beat action (load acc, klen, cnt) and go to HOLD or ACC by the new klen. No bubble occurs between tiles.
  - On !out_ready: data_out and out_valid stay stable, and no input is accepted.
- Latency: out_valid rises the cycle after the last beat of a tile is accepted.
- Throughput: one beat per cycle. A tile of K beats occupies K cycles plus zero extra cycles under continuous ready.
- Arithmetic:
  - Per-lane two's-complement add, modulo 2^DATA_WIDTH; wraps silently.
  - No saturation and no carry-out.
  - Lanes are independent.
- k_len_in is ignored except on first beats, so changing it mid-tile has no effect.
- data_out is registered, and output ports are driven only from registers and state (no combinational path from data_in to data_out).
- in_ready depends combinationally on out_ready only in HOLD.
- Reset mid-tile or mid-HOLD discards the partial or unconsumed result with no output transfer.

Test Plan:
- Basic tile: rst for 2 cycles; k_len=4; send 4 beats, lane i = i+1 each beat. Required: out_valid the cycle after beat 4, data_out = {16,12,8,4} (lane3..lane0), exactly one output transfer.
- Wrap-around: k_len=2, lane0 beats 0xFFFF_FFFF then 0x0000_0002. Required: data_out[0] = 0x0000_0001. Signed lanes: -5 then +3 gives 0xFFFF_FFFE.
- Back-pressure and bubbles: k_len=3, in_valid toggled 1,0,1,0,1, with out_ready=0 for 5 cycles after completion. Required:
  - sum correct;
  - out_valid and data_out stable while stalled;
  - in_ready=0 in HOLD;
  - a next-tile beat offered during the stall is not accepted until out_ready=1.
- Back-to-back tiles: k_len=1 with out_ready=1 and in_valid=1 continuously, beats 10,20,30. Required: outputs 10,20,30 on consecutive cycles and in_ready constantly 1.
- k_len edge cases: k_len=0 behaves as 1. k_len changed from 4 to 2 on beat 2 of a tile does not end the tile; it still completes after 4 beats.
- Reset mid-operation: rst asserted after 2 of 4 beats. Required: out_valid=0 and data_out=0 after reset; the next tile of 4 beats of value 1 yields exactly 4 per lane, with no residue.
